// File: rtl/slowfil_mc_if.sv
// Bundle for slowfil_mc: coefficient load port, sample-set strobe, and the
// channel-tagged serial result stream. There is no backpressure on results.
interface slowfil_mc_if #(
    parameter int NCHAN = 4,
    parameter int IW    = 16,
    parameter int TW    = 16,
    parameter int OW    = 39
);
    localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

    logic                  i_tap_wr;
    logic [TW-1:0]         i_tap;
    logic                  i_ce;
    logic [NCHAN*IW-1:0]   i_sample;
    logic                  o_busy;
    logic                  o_overrun;
    logic                  o_ce;
    logic [CW-1:0]         o_chan;
    logic [OW-1:0]         o_result;

    modport master (
        output i_tap_wr, i_tap, i_ce, i_sample,
        input  o_busy, o_overrun, o_ce, o_chan, o_result
    );

    modport slave (
        input  i_tap_wr, i_tap, i_ce, i_sample,
        output o_busy, o_overrun, o_ce, o_chan, o_result
    );
endinterface

// File: rtl/slowfil_mc.sv
// Multi-channel FIR sharing one multiplier; channel k result NTAPS*(k+1)+3 clocks after i_ce.
// i_ce while busy is dropped and flagged in o_overrun. SLOWFIL_MC_ROUND_EN adds half-to-even rounding (+1 clock).
module slowfil_mc #(
    parameter int NCHAN   = 4,
    parameter int LGNTAPS = 7,
    parameter int NTAPS   = 110,
    parameter int IW      = 16,
    parameter int TW      = 16,
    parameter int OW      = IW + TW + LGNTAPS
) (
    input  logic        i_clk,
    input  logic        i_reset,
    slowfil_mc_if.slave bus
);
    localparam int AW   = IW + TW + LGNTAPS;
    localparam int PW   = IW + TW;
    localparam int CW   = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int DROP = AW - OW;
    localparam logic [LGNTAPS-1:0] LAST_T = LGNTAPS'(NTAPS - 1);
    localparam logic [CW-1:0]      LAST_C = CW'(NCHAN - 1);
`ifdef SLOWFIL_MC_ROUND_EN
    localparam int FLUSH_N = 4;
    localparam int HB      = (DROP > 0) ? DROP - 1 : 0;
    localparam logic [AW-1:0] HALF_M = (DROP > 0) ? ({{(AW-1){1'b0}}, 1'b1} << HB) : '0;
    localparam logic [AW-1:0] REST_M = (DROP > 0) ? (HALF_M - {{(AW-1){1'b0}}, 1'b1}) : '0;
    localparam logic [OW-1:0] MAXPOS = {1'b0, {(OW-1){1'b1}}};
`else
    localparam int FLUSH_N = 3;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        chan_q, chan_d;
    logic [LGNTAPS-1:0]   tidx_q, tidx_d;
    logic [2:0]           fcnt_q, fcnt_d;
    logic [LGNTAPS-1:0]   widx_q;
    logic                 busy, accept, iss_vld;
    logic                 tap_we, pend_apply, pend_q;
    logic [TW-1:0]        pend_dat_q, tap_wdat;
    logic                 overrun_q;

    logic signed [TW-1:0] tapmem_q [NTAPS];
    logic signed [IW-1:0] dl_q [NCHAN][NTAPS];

    logic                 rd_vld_q, rd_first_q, rd_last_q;
    logic [CW-1:0]        rd_chan_q;
    logic signed [TW-1:0] rd_tap_q;
    logic signed [IW-1:0] rd_x_q;
    logic                 pr_vld_q, pr_first_q, pr_last_q;
    logic [CW-1:0]        pr_chan_q;
    logic signed [PW-1:0] prod_q;
    logic signed [AW-1:0] acc_q, acc_sum;

    logic                 ce_q;
    logic [CW-1:0]        chan_out_q;
    logic [OW-1:0]        result_q;
`ifdef SLOWFIL_MC_ROUND_EN
    logic                 fin_vld_q;
    logic [CW-1:0]        fin_chan_q;
    logic signed [AW-1:0] fin_acc_q;
`endif

    function automatic logic [OW-1:0] scale(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] keep;
        logic [OW-1:0]        k;
`ifdef SLOWFIL_MC_ROUND_EN
        logic                 half, rest, up;
`endif
        keep = a >>> DROP;
        k    = keep[OW-1:0];
`ifdef SLOWFIL_MC_ROUND_EN
        half = |(a & HALF_M);
        rest = |(a & REST_M);
        up   = half && (rest || k[0]);
        if (up && (k != MAXPOS))
            k = k + OW'(1);
`endif
        return k;
    endfunction

    assign busy   = (state_q != S_IDLE);
    assign accept = bus.i_ce && !busy && !i_reset;
    assign pend_apply = pend_q && (state_q == S_FLUSH) && (fcnt_q == 3'(FLUSH_N - 1)) && !i_reset;
    // A write arriving with i_ce is parked until the set finishes so the set uses the old tap.
    assign tap_we   = (bus.i_tap_wr && !busy && !bus.i_ce && !i_reset) || pend_apply;
    assign tap_wdat = pend_apply ? pend_dat_q : bus.i_tap;

    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        tidx_d  = tidx_q;
        fcnt_d  = fcnt_q;
        iss_vld = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_RUN;
                    chan_d  = '0;
                    tidx_d  = '0;
                end
            end
            S_RUN: begin
                iss_vld = 1'b1;
                if (tidx_q == LAST_T) begin
                    tidx_d = '0;
                    if (chan_q == LAST_C) begin
                        state_d = S_FLUSH;
                        fcnt_d  = '0;
                    end else begin
                        chan_d = chan_q + CW'(1);
                    end
                end else begin
                    tidx_d = tidx_q + LGNTAPS'(1);
                end
            end
            S_FLUSH: begin
                if (fcnt_q == 3'(FLUSH_N - 1))
                    state_d = S_IDLE;
                else
                    fcnt_d = fcnt_q + 3'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        acc_sum = pr_first_q ? AW'(prod_q) : (acc_q + AW'(prod_q));
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            chan_q     <= '0;
            tidx_q     <= '0;
            fcnt_q     <= '0;
            widx_q     <= '0;
            pend_q     <= 1'b0;
            overrun_q  <= 1'b0;
            rd_vld_q   <= 1'b0;
            pr_vld_q   <= 1'b0;
            ce_q       <= 1'b0;
            chan_out_q <= '0;
            result_q   <= '0;
`ifdef SLOWFIL_MC_ROUND_EN
            fin_vld_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            chan_q   <= chan_d;
            tidx_q   <= tidx_d;
            fcnt_q   <= fcnt_d;
            rd_vld_q <= iss_vld;
            pr_vld_q <= rd_vld_q;
            if (tap_we)
                widx_q <= (widx_q == LAST_T) ? '0 : widx_q + LGNTAPS'(1);
            if (accept && bus.i_tap_wr)
                pend_q <= 1'b1;
            else if (pend_apply)
                pend_q <= 1'b0;
            if (bus.i_ce && busy)
                overrun_q <= 1'b1;
`ifdef SLOWFIL_MC_ROUND_EN
            fin_vld_q <= pr_vld_q && pr_last_q;
            ce_q      <= fin_vld_q;
            if (fin_vld_q) begin
                chan_out_q <= fin_chan_q;
                result_q   <= scale(fin_acc_q);
            end
`else
            ce_q <= pr_vld_q && pr_last_q;
            if (pr_vld_q && pr_last_q) begin
                chan_out_q <= pr_chan_q;
                result_q   <= scale(acc_sum);
            end
`endif
        end
    end

    // Storage and datapath payload: qualified by the valid bits above, never reset.
    always_ff @(posedge i_clk) begin
        if (tap_we)
            tapmem_q[widx_q] <= tap_wdat;
        if (accept) begin
            for (int c = 0; c < NCHAN; c++) begin
                dl_q[c][0] <= bus.i_sample[c*IW +: IW];
                for (int t = 1; t < NTAPS; t++)
                    dl_q[c][t] <= dl_q[c][t-1];
            end
        end
        if (accept && bus.i_tap_wr)
            pend_dat_q <= bus.i_tap;
        rd_chan_q  <= chan_q;
        rd_first_q <= (tidx_q == '0);
        rd_last_q  <= (tidx_q == LAST_T);
        rd_tap_q   <= tapmem_q[tidx_q];
        rd_x_q     <= dl_q[chan_q][tidx_q];
        pr_chan_q  <= rd_chan_q;
        pr_first_q <= rd_first_q;
        pr_last_q  <= rd_last_q;
        prod_q     <= PW'(rd_tap_q) * PW'(rd_x_q);
        if (pr_vld_q)
            acc_q <= acc_sum;
`ifdef SLOWFIL_MC_ROUND_EN
        if (pr_vld_q && pr_last_q) begin
            fin_acc_q  <= acc_sum;
            fin_chan_q <= pr_chan_q;
        end
`endif
    end

    assign bus.o_busy    = busy;
    assign bus.o_overrun = overrun_q;
    assign bus.o_ce      = ce_q;
    assign bus.o_chan    = chan_out_q;
    assign bus.o_result  = result_q;
endmodule

// File: tb/tb_slowfil_mc.sv
// Directed bench for slowfil_mc: 2 channels, 4 taps; a second instance with OW=AW-4 covers output scaling.
module tb_slowfil_mc;
    localparam int NCH = 2;
    localparam int LGT = 2;
    localparam int NT  = 4;
    localparam int IW  = 16;
    localparam int TW  = 16;
    localparam int AW  = IW + TW + LGT;
    localparam int OWB = AW - 4;
`ifdef SLOWFIL_MC_ROUND_EN
    localparam int XL = 1;
`else
    localparam int XL = 0;
`endif
    localparam int T0  = NT + 3 + XL;
    localparam int T1  = 2 * NT + 3 + XL;
    localparam int TBF = NCH * NT + 4 + XL;
    localparam int LIM = 16;

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic                i_reset;
    logic                tap_wr, ce;
    logic [TW-1:0]       tap;
    logic [NCH*IW-1:0]   sample;

    slowfil_mc_if #(.NCHAN(NCH), .IW(IW), .TW(TW), .OW(AW))  bus_a ();
    slowfil_mc_if #(.NCHAN(NCH), .IW(IW), .TW(TW), .OW(OWB)) bus_b ();

    assign bus_a.i_tap_wr = tap_wr;
    assign bus_a.i_tap    = tap;
    assign bus_a.i_ce     = ce;
    assign bus_a.i_sample = sample;
    assign bus_b.i_tap_wr = tap_wr;
    assign bus_b.i_tap    = tap;
    assign bus_b.i_ce     = ce;
    assign bus_b.i_sample = sample;

    slowfil_mc #(.NCHAN(NCH), .LGNTAPS(LGT), .NTAPS(NT), .IW(IW), .TW(TW), .OW(AW)) dut_a (
        .i_clk(i_clk), .i_reset(i_reset), .bus(bus_a));
    slowfil_mc #(.NCHAN(NCH), .LGNTAPS(LGT), .NTAPS(NT), .IW(IW), .TW(TW), .OW(OWB)) dut_b (
        .i_clk(i_clk), .i_reset(i_reset), .bus(bus_b));

    typedef struct {
        logic signed [15:0] s0, s1;
        logic signed [63:0] e0, e1, eb0, eb1;
        bit                 chk, chkb, ovr_exp;
        int                 ovr, tw;
        logic [15:0]        twv;
    } vec_t;

    vec_t tbl [26];
    int errors, checks;
    int n_ce, busy1, busy_fall;
    logic signed [63:0] cap_res [2];
    logic signed [63:0] cap_rb  [2];
    int cap_chan [2];
    int cap_cyc  [2];

    function automatic vec_t mk(input int s0, input int s1, input int e0, input int e1, input bit c);
        vec_t v;
        v.s0 = 16'(s0);   v.s1 = 16'(s1);
        v.e0 = 64'(e0);   v.e1 = 64'(e1);
        v.eb0 = '0;       v.eb1 = '0;
        v.chk = c;        v.chkb = 1'b0;  v.ovr_exp = 1'b0;
        v.ovr = -1;       v.tw = -1;      v.twv = '0;
        return v;
    endfunction

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic write_tap(input int v);
        tap = 16'(v);
        tap_wr = 1'b1;
        @(posedge i_clk); #1;
        tap_wr = 1'b0;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
    endtask

    // Accept one sample set at cycle 0 and record o_ce timing/values for LIM cycles.
    task automatic run_set(input vec_t v);
        n_ce = 0;
        busy1 = 0;
        busy_fall = -1;
        for (int k = 0; k < 2; k++) begin
            cap_res[k] = 'x; cap_rb[k] = 'x; cap_chan[k] = -1; cap_cyc[k] = -1;
        end
        sample = {v.s1, v.s0};
        ce = 1'b1;
        tap_wr = (v.tw == 0);
        tap = v.twv;
        @(posedge i_clk); #1;
        for (int cyc = 1; cyc <= LIM; cyc++) begin
            if (bus_a.o_ce) begin
                if (n_ce < 2) begin
                    cap_res[n_ce]  = $signed(bus_a.o_result);
                    cap_rb[n_ce]   = $signed(bus_b.o_result);
                    cap_chan[n_ce] = int'(bus_a.o_chan);
                    cap_cyc[n_ce]  = cyc;
                end
                n_ce++;
            end
            if (cyc == 1) busy1 = int'(bus_a.o_busy);
            if (!bus_a.o_busy && busy_fall < 0) busy_fall = cyc;
            ce = (cyc == v.ovr);
            if (cyc == v.ovr) sample = {16'sd1000, 16'sd1000};
            tap_wr = (cyc == v.tw);
            @(posedge i_clk); #1;
        end
        ce = 1'b0;
        tap_wr = 1'b0;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = tbl[i];
        run_set(v);
        chk($sformatf("v%0d.n_ce", i), n_ce, 2);
        chk($sformatf("v%0d.chan0", i), cap_chan[0], 0);
        chk($sformatf("v%0d.chan1", i), cap_chan[1], 1);
        chk($sformatf("v%0d.cyc0", i), cap_cyc[0], T0);
        chk($sformatf("v%0d.cyc1", i), cap_cyc[1], T1);
        chk($sformatf("v%0d.busy1", i), busy1, 1);
        chk($sformatf("v%0d.busy_fall", i), busy_fall, TBF);
        chk($sformatf("v%0d.overrun", i), bus_a.o_overrun, v.ovr_exp);
        if (v.chk) begin
            chk($sformatf("v%0d.res0", i), cap_res[0], v.e0);
            chk($sformatf("v%0d.res1", i), cap_res[1], v.e1);
            chk($sformatf("v%0d.hold_res", i), $signed(bus_a.o_result), v.e1);
            chk($sformatf("v%0d.hold_chan", i), bus_a.o_chan, 1);
        end
        if (v.chkb) begin
            chk($sformatf("v%0d.scaled0", i), cap_rb[0], v.eb0);
            chk($sformatf("v%0d.scaled1", i), cap_rb[1], v.eb1);
        end
    endtask

    initial begin
        int n;
        errors = 0;
        checks = 0;
        tap_wr = 1'b0;
        tap = '0;
        ce = 1'b0;
        sample = '0;
        i_reset = 1'b1;

        // Taps {1,2,3,4}: prime with zeros, impulse, then constant -1/5.
        for (int i = 0; i < 3; i++) tbl[i] = mk(0, 0, 0, 0, 1'b0);
        tbl[3]  = mk(0, 0, 0, 0, 1'b1);
        tbl[4]  = mk(100, 0, 100, 0, 1'b1);
        tbl[5]  = mk(0, 0, 200, 0, 1'b1);
        tbl[6]  = mk(0, 0, 300, 0, 1'b1);
        tbl[7]  = mk(0, 0, 400, 0, 1'b1);
        tbl[8]  = mk(-1, 5, -1, 5, 1'b1);
        tbl[9]  = mk(-1, 5, -3, 15, 1'b1);
        tbl[10] = mk(-1, 5, -6, 30, 1'b1);
        tbl[11] = mk(-1, 5, -10, 50, 1'b1);
        // Overrun pulse 3 cycles in must not shift the delay lines.
        tbl[12] = mk(2, 0, -7, 45, 1'b1);
        tbl[12].ovr = 3;
        tbl[12].ovr_exp = 1'b1;
        tbl[13] = mk(0, 0, -3, 35, 1'b1);
        tbl[13].ovr_exp = 1'b1;
        // Taps {7,2,3,4} after wrapped writes; write of 99 while busy must be dropped.
        tbl[14] = mk(0, 0, 2, 20, 1'b1);
        tbl[15] = mk(0, 0, 8, 0, 1'b1);
        tbl[16] = mk(1, 0, 7, 0, 1'b1);
        tbl[16].tw = 2;
        tbl[16].twv = 16'd99;
        tbl[17] = mk(0, 0, 2, 0, 1'b1);
        tbl[18] = mk(0, 0, 3, 0, 1'b1);
        tbl[19] = mk(0, 0, 4, 0, 1'b1);
        // After the aborted set (5,6): delay lines hold it one position in.
        tbl[20] = mk(0, 0, 10, 12, 1'b1);
        // Taps {1,0,0,0}: output equals newest sample; scaled instance drops 4 LSBs.
        tbl[21] = mk(24, 40, 24, 40, 1'b1);
        tbl[21].chkb = 1'b1;
        tbl[22] = mk(-24, 8, -24, 8, 1'b1);
        tbl[23] = mk(-8, 56, -8, 56, 1'b1);
        tbl[23].chkb = 1'b1;
`ifdef SLOWFIL_MC_ROUND_EN
        tbl[21].eb0 = 2;  tbl[21].eb1 = 2;
        tbl[23].eb0 = 0;  tbl[23].eb1 = 4;
`else
        tbl[21].eb0 = 1;  tbl[21].eb1 = 2;
        tbl[23].eb0 = -1; tbl[23].eb1 = 3;
`endif
        // Tap write together with i_ce: this set uses old tap[0]=1, the next sees 50.
        tbl[24] = mk(3, 0, 3, 0, 1'b1);
        tbl[24].tw = 0;
        tbl[24].twv = 16'd50;
        tbl[25] = mk(1, 0, 50, 0, 1'b1);

        repeat (2) @(posedge i_clk);
        #1;
        chk("rst.busy", bus_a.o_busy, 0);
        chk("rst.overrun", bus_a.o_overrun, 0);
        chk("rst.o_ce", bus_a.o_ce, 0);
        chk("rst.chan", bus_a.o_chan, 0);
        chk("rst.result", $signed(bus_a.o_result), 0);
        chk("rst.result_b", $signed(bus_b.o_result), 0);
        i_reset = 1'b0;

        write_tap(1); write_tap(2); write_tap(3); write_tap(4);
        for (int i = 0; i <= 13; i++) run_vec(i);

        do_reset();
        chk("ovr.cleared", bus_a.o_overrun, 0);
        write_tap(9); write_tap(2); write_tap(3); write_tap(4); write_tap(7);
        for (int i = 14; i <= 19; i++) run_vec(i);

        // Reset during RUN aborts the set with no further results.
        sample = {16'sd6, 16'sd5};
        ce = 1'b1;
        @(posedge i_clk); #1;
        ce = 1'b0;
        repeat (4) begin
            @(posedge i_clk); #1;
        end
        chk("abort.busy_pre", bus_a.o_busy, 1);
        do_reset();
        chk("abort.busy_post", bus_a.o_busy, 0);
        n = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus_a.o_ce) n++;
            @(posedge i_clk); #1;
        end
        chk("abort.no_ce", n, 0);
        run_vec(20);

        write_tap(1); write_tap(0); write_tap(0); write_tap(0);
        for (int i = 21; i <= 25; i++) run_vec(i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/slowfil_mc.md
Name: slowfil_mc

Overview:
Multi-channel, single-multiplier FIR filter: one DSP multiply shared across all taps and all channels.
- NCHAN parallel input samples arrive on one strobe and are stored in per-channel shift-register delay lines.
- Tap coefficients are one shared set for all channels.
- Channels are filtered back-to-back, and results are emitted serially with a channel tag.
- Sits after a multi-channel ADC or decimator, where samples arrive at least NCHAN*NTAPS+4 clocks apart.

Parameters:
NCHAN, 4, number of channels (>=1)
LGNTAPS, 7, log2 of maximum tap count
NTAPS, 110, taps used (2..2**LGNTAPS)
IW, 16, signed input sample width
TW, 16, signed coefficient width
OW, IW+TW+LGNTAPS, output width (<= AW); AW=IW+TW+LGNTAPS is the internal accumulator width (localparam)

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
i_tap_wr  in  1  coefficient write strobe
i_tap  in  TW  signed coefficient
i_ce  in  1  new sample set valid
i_sample  in  NCHAN*IW  channel k occupies bits [k*IW +: IW]
o_busy  out  1  high while a sample set is being processed
o_overrun  out  1  sticky: i_ce arrived while busy
o_ce  out  1  result valid (one-cycle pulse)
o_chan  out  max(1,$clog2(NCHAN))  channel of o_result
o_result  out  OW  signed filter output

Behaviour:
- Reset is i_reset, synchronous, active-high, on clock i_clk.
- Reset values: o_busy=0, o_overrun=0, o_ce=0, o_chan=0, o_result=0, write index=0, FSM=IDLE. Delay lines and tap memory are not reset.
- Tap write: i_tap_wr while !o_busy writes tapmem[widx]<=i_tap, then widx increments.
  - widx wraps NTAPS-1 -> 0.
  - i_tap_wr while o_busy is ignored and widx holds.
- Sample accept: i_ce while !o_busy shifts every channel delay line (x[0]<=new sample, x[t]<=x[t-1]).
  - i_ce while o_busy is ignored (no shift) and sets o_overrun until reset.
- FSM:
  - IDLE -> RUN on accepted i_ce; chan=0, tidx=0.
  - RUN issues one (chan,tidx) per clock. tidx counts 0..NTAPS-1, then chan increments and tidx returns to 0 with no bubble.
  - After (NCHAN-1,NTAPS-1) is issued: FLUSH for 3 clocks, then IDLE.
- Pipeline: issue -> read (tap[tidx], x_chan[tidx]) -> product (IW+TW, signed) -> accumulate.
  - The accumulator loads the product on tidx=0 and adds a sign-extended product otherwise.
- Computation: y_chan = sum over t=0..NTAPS-1 of tap[t]*x_chan[t], accumulated in AW bits. The accumulator cannot overflow.
- Timing (accepted i_ce at cycle 0):
  - Channel k result: o_ce at cycle NTAPS*(k+1)+3, with o_chan=k.
  - o_busy high cycles 1..NCHAN*NTAPS+3 inclusive, so it falls the cycle after the last o_ce.
  - i_ce is next accepted at cycle NCHAN*NTAPS+4.
- Output scaling: o_result = acc[AW-1 -: OW] (truncation) when OW<AW; o_result = acc when OW==AW.
- o_result and o_chan hold their values between o_ce pulses.
- Reset mid-operation: the FSM aborts to IDLE and no further o_ce occurs. Delay-line contents are retained.
- Simultaneous i_ce and i_tap_wr while idle: both take effect, and the computation uses the old tap.

Optional Feature:
SLOWFIL_MC_ROUND_EN
- Defined: when OW<AW, o_result is rounded half-to-even from acc by dropping AW-OW LSBs.
  - This costs one extra pipeline stage: o_ce timing and o_busy end shift +1 cycle; next accept at NCHAN*NTAPS+5.
  - Saturate to OW bits on positive overflow from rounding.
- Undefined: truncation as above.
- With OW==AW, the macro has no effect other than the extra cycle.

Test Plan:
1. NCHAN=2, NTAPS=4, taps {1,2,3,4}; i_sample ch0=100, ch1=0, then three sets of zeros -> ch0 outputs 100,200,300,400, ch1 always 0. The first o_ce (ch0) occurs exactly 7 clocks after i_ce, and ch1 follows 4 clocks later.
2. Same taps; ch0=-1, ch1=5 constant for 4 sets -> 4th set outputs ch0=-10, ch1=50; o_chan sequence 0,1 per set.
3. i_ce pulsed 3 cycles after an accepted i_ce -> no shift, o_overrun=1 until i_reset, and the results of the first set are unchanged.
4. Five tap writes with NTAPS=4 (values 9,2,3,4,7) -> widx wraps, tap[0]=7. Impulse 1 on ch0 then gives 7,2,3,4. A tap write while busy is ignored.
5. i_reset asserted in RUN -> o_busy=0 next cycle, no o_ce afterwards; a subsequent i_ce is accepted normally.
6. OW=AW-4, acc=0x...18 vs 0x...28, with and without SLOWFIL_MC_ROUND_EN -> truncation gives 1 and 2; rounding gives 2 and 2 (half-to-even).
